// File: rtl/button_event_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// button_event_ctrl_pkg
//
// Purpose: shared definitions for the crane-game button debounce / event
//          scheduler. Holds the width helper functions, default tick timing,
//          the logical button index map and the scan FSM state type.
//
// Contents:
//   clog2()          ceil(log2(value)), 0 for value <= 1
//   cnt_width()      bits needed to hold 0..max_value, never less than 1
//   TICK_DIV_2P5MS   system clocks per 2.5 ms sample tick at 100 MHz
//   BTN_*            bit positions of each control button in btn_raw
//   scan_state_t     IDLE / SCAN states of the time-multiplexed update path
// -----------------------------------------------------------------------------
package button_event_ctrl_pkg;

    localparam int TICK_DIV_2P5MS = 250000;

    // Bit positions of the physical controls inside the button vector.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_DROP  = 4;
    localparam int BTN_COUNT = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of a counter that must hold every value 0..max_value.
    function automatic int cnt_width(input int max_value);
        int w;
        w = clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_event_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// button_event_ctrl_tick_gen
//
// Purpose: sample-tick divider for the button scanner. Counts system clocks
//          0..TICK_DIV-1 while enabled and strobes sample_tick in the cycle
//          the counter sits on its last value. Disabling holds the counter at
//          zero so the next tick is a full period after re-enable.
//
// Ports:
//   clock        in   system clock
//   resetn       in   asynchronous active-low reset
//   enable       in   1 = run the divider, 0 = hold counter at 0
//   sample_tick  out  one-clock strobe at the start of each scan
// -----------------------------------------------------------------------------
module button_event_ctrl_tick_gen
    import button_event_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_2P5MS
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    output logic sample_tick
);

    localparam int              CNT_W    = cnt_width(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (!enable || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Gated by enable so a falling enable in the last-count cycle never
    // launches a scan.
    assign sample_tick = enable & w_last;

endmodule

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
//
// Purpose: shared debounce and event scheduler for all crane-game control
//          buttons. One tick divider and one time-multiplexed update path
//          service N_BTN buttons in turn: on every sample tick the scan FSM
//          visits button 0..N_BTN-1, one per clock, updating its stable
//          counter, debounced level and hold counter. Everything runs on the
//          system clock; no derived clocks.
//
// Ports:
//   clock          in   system clock (100 MHz)
//   resetn         in   asynchronous active-low reset
//   enable         in   run sample ticks (0 holds the divider at 0)
//   btn_raw        in   [N_BTN] raw asynchronous buttons, active-high
//   btn_level      out  [N_BTN] debounced level
//   press_pulse    out  [N_BTN] one-clock pulse on accepted 0->1
//   release_pulse  out  [N_BTN] one-clock pulse on accepted 1->0
//   repeat_pulse   out  [N_BTN] one-clock auto-repeat pulse while held
//   sample_tick    out  one-clock strobe at the start of each scan
// -----------------------------------------------------------------------------
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int N_BTN        = BTN_COUNT,
    parameter int TICK_DIV     = TICK_DIV_2P5MS,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 40
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             sample_tick
);

    localparam int IDX_W  = cnt_width(N_BTN - 1);
    localparam int STB_W  = 4;
    localparam int HOLD_W = clog2(REPEAT_DELAY + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(N_BTN - 1);
    localparam logic [STB_W-1:0]  STB_ACCEPT  = STB_W'(STABLE_CNT);
    localparam logic [HOLD_W-1:0] HOLD_FIRST  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

    // Two-flop synchronizer per button; r_sync2 is the value the scan sees.
    logic [N_BTN-1:0]  r_sync1;
    logic [N_BTN-1:0]  r_sync2;

    // Per-button state, touched only in that button's scan slot.
    logic [STB_W-1:0]  r_stable [N_BTN];
    logic [HOLD_W-1:0] r_hold   [N_BTN];

    scan_state_t       r_state;
    logic [IDX_W-1:0]  r_idx;

    logic              w_tick;
    logic              w_sync;
    logic              w_level;
    logic [STB_W-1:0]  w_stb_inc;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              w_differ;
    logic              w_toggle;
    logic              w_repeat;

    button_event_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .sample_tick (w_tick)
    );

    assign sample_tick = w_tick;

    // Decode of the button currently in its scan slot.
    always_comb begin
        w_sync     = r_sync2[r_idx];
        w_level    = btn_level[r_idx];
        w_stb_inc  = r_stable[r_idx] + 1'b1;
        w_hold_inc = r_hold[r_idx] + 1'b1;
        w_differ   = (w_sync != w_level);
        w_toggle   = w_differ && (w_stb_inc == STB_ACCEPT);
        // A toggle in the same slot wins over a repeat.
        w_repeat   = w_level && !w_toggle && (w_hold_inc == HOLD_FIRST);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1       <= '0;
            r_sync2       <= '0;
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_stable[i] <= '0;
                r_hold[i]   <= '0;
            end
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;

            // Pulses are single-clock unless re-asserted by a slot below.
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_SCAN;
                        r_idx   <= '0;
                    end
                end

                ST_SCAN: begin
                    // Debounce: count consecutive samples that disagree with
                    // the accepted level; any agreeing sample restarts it.
                    if (!w_differ) begin
                        r_stable[r_idx] <= '0;
                    end else if (w_toggle) begin
                        r_stable[r_idx]      <= '0;
                        btn_level[r_idx]     <= ~w_level;
                        press_pulse[r_idx]   <= ~w_level;
                        release_pulse[r_idx] <= w_level;
                    end else begin
                        r_stable[r_idx] <= w_stb_inc;
                    end

                    // Hold timer: counts slots spent at level 1. After the
                    // first repeat it is reloaded so the next one fires
                    // REPEAT_RATE slots later; it therefore never wraps.
                    if (w_toggle || !w_level) begin
                        r_hold[r_idx] <= '0;
                    end else if (w_repeat) begin
                        r_hold[r_idx]       <= HOLD_RELOAD;
                        repeat_pulse[r_idx] <= 1'b1;
                    end else begin
                        r_hold[r_idx] <= w_hold_inc;
                    end

                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_event_ctrl
//
// Reference model: after every clock edge it replays the debounce rules on an
// abstract view (raw value seen two edges ago, tick phase, scan slot number,
// run length of disagreeing samples, number of slots held) and pushes the
// pulse each slot must produce into a scoreboard queue. A separate monitor on
// the falling edge pops that queue whenever the DUT shows a pulse and also
// compares the debounced levels and sample_tick every cycle.
// -----------------------------------------------------------------------------
module tb_button_event_ctrl;

    localparam int N_BTN        = 2;
    localparam int TICK_DIV     = 8;
    localparam int STABLE_CNT   = 3;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_REPEAT  = 2;

    typedef struct {
        int cyc;
        int btn;
        int kind;
    } ev_t;

    logic             clock   = 1'b0;
    logic             resetn  = 1'b1;
    logic             enable  = 1'b1;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] repeat_pulse;
    logic             sample_tick;

    // Scoreboard and counters (counters owned by the monitor).
    ev_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    // Stimulus -> monitor handshakes.
    int  stim_timeouts = 0;
    int  seen_timeouts = 0;
    bit  stim_done     = 1'b0;

    // Model state.
    int               m_cyc   = 0;
    int               m_cnt   = 0;
    int               m_slot  = -1;
    logic [N_BTN-1:0] m_level = '0;
    int               m_diff [N_BTN];
    int               m_held [N_BTN];
    logic [N_BTN-1:0] m_hist[$];
    logic [N_BTN-1:0] m_smp;
    logic             m_tick_before;

    // Monitor scratch.
    ev_t  mon_e;
    logic mon_hit;

    button_event_ctrl #(
        .N_BTN        (N_BTN),
        .TICK_DIV     (TICK_DIV),
        .STABLE_CNT   (STABLE_CNT),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .enable        (enable),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .sample_tick   (sample_tick)
    );

    always #5 clock = ~clock;

    // ---------------------------------------------------------------- model
    task automatic model_reset();
        m_cyc   = 0;
        m_cnt   = 0;
        m_slot  = -1;
        m_level = '0;
        for (int i = 0; i < N_BTN; i++) begin
            m_diff[i] = 0;
            m_held[i] = 0;
        end
        m_hist.delete();
        m_hist.push_back('0);
        m_hist.push_back('0);
    endtask

    task automatic push_ev(input int b, input int kind);
        ev_t e;
        e.cyc  = m_cyc;
        e.btn  = b;
        e.kind = kind;
        sb_q.push_back(e);
    endtask

    task automatic scan_button(input int b, input logic s);
        if (s == m_level[b]) begin
            m_diff[b] = 0;
        end else begin
            m_diff[b] = m_diff[b] + 1;
            if (m_diff[b] == STABLE_CNT) begin
                m_diff[b]  = 0;
                m_level[b] = s;
                m_held[b]  = 0;
                push_ev(b, s ? K_PRESS : K_RELEASE);
                return;
            end
        end
        if (m_level[b]) begin
            m_held[b] = m_held[b] + 1;
            if (m_held[b] >= REPEAT_DELAY &&
                ((m_held[b] - REPEAT_DELAY) % REPEAT_RATE) == 0)
                push_ev(b, K_REPEAT);
        end else begin
            m_held[b] = 0;
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (!resetn) begin
            model_reset();
        end else begin
            m_cyc = m_cyc + 1;
            m_smp = m_hist[0];
            m_hist.push_back(btn_raw);
            void'(m_hist.pop_front());
            m_tick_before = enable && (m_cnt == TICK_DIV - 1);
            m_cnt = enable ? (m_cnt + 1) % TICK_DIV : 0;
            if (m_slot >= 0) begin
                scan_button(m_slot, m_smp[m_slot]);
                m_slot = m_slot + 1;
                if (m_slot == N_BTN) m_slot = -1;
            end else if (m_tick_before) begin
                m_slot = 0;
            end
        end
    end

    // -------------------------------------------------------------- monitor
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    always @(negedge clock) begin
        if (stim_timeouts != seen_timeouts) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL tick_wait: actual=no sample_tick within budget required=sample_tick");
            seen_timeouts = stim_timeouts;
        end

        if (!resetn) begin
            sb_q.delete();
            check("reset_outputs",
                  32'({btn_level, press_pulse, release_pulse, repeat_pulse, sample_tick}), 32'd0);
        end else begin
            while (sb_q.size() > 0 && sb_q[0].cyc < m_cyc) begin
                mon_e = sb_q.pop_front();
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL missed_pulse: actual=none required=btn%0d kind%0d at cycle %0d",
                         mon_e.btn, mon_e.kind, mon_e.cyc);
            end

            check("btn_level", 32'(btn_level), 32'(m_level));
            check("sample_tick", 32'(sample_tick), 32'(enable && (m_cnt == TICK_DIV - 1)));

            for (int b = 0; b < N_BTN; b++) begin
                for (int k = 0; k < 3; k++) begin
                    mon_hit = (k == K_PRESS)   ? press_pulse[b] :
                              (k == K_RELEASE) ? release_pulse[b] : repeat_pulse[b];
                    if (mon_hit) begin
                        total = total + 1;
                        if (sb_q.size() == 0) begin
                            bad = bad + 1;
                            $display("FAIL unexpected_pulse: actual=btn%0d kind%0d at cycle %0d required=none",
                                     b, k, m_cyc);
                        end else begin
                            mon_e = sb_q.pop_front();
                            if (mon_e.cyc != m_cyc || mon_e.btn != b || mon_e.kind != k) begin
                                bad = bad + 1;
                                $display("FAIL pulse: actual=btn%0d kind%0d cycle %0d required=btn%0d kind%0d cycle %0d",
                                         b, k, m_cyc, mon_e.btn, mon_e.kind, mon_e.cyc);
                            end
                        end
                    end
                end
            end
        end

        if (stim_done) begin
            total = total + 1;
            if (sb_q.size() != 0) begin
                bad = bad + 1;
                $display("FAIL pending_events: actual=%0d left required=0", sb_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #3;
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (sample_tick !== 1'b1 && n < 4 * TICK_DIV) begin
            idle(1);
            n++;
        end
        if (sample_tick !== 1'b1) stim_timeouts = stim_timeouts + 1;
    endtask

    initial begin
        #2 resetn = 1'b0;
        // Reset held while the raw inputs wiggle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #3;
            btn_raw = N_BTN'($urandom);
        end
        idle(1);
        btn_raw = '0;
        resetn  = 1'b1;
        idle(20);

        // Clean press on button 0, held long enough for several repeats.
        btn_raw[0] = 1'b1;
        idle(TICK_DIV * 16);
        // Release.
        btn_raw[0] = 1'b0;
        idle(TICK_DIV * 6);

        // Tick-aligned bounce on button 1 for 20 ticks.
        wait_tick();
        for (int i = 0; i < 20; i++) begin
            btn_raw[1] = ~btn_raw[1];
            idle(TICK_DIV);
        end
        btn_raw[1] = 1'b0;
        idle(TICK_DIV * 5);

        // Enable dropped while button 0 is held.
        btn_raw[0] = 1'b1;
        idle(TICK_DIV * 5);
        enable = 1'b0;
        idle(40);
        enable = 1'b1;
        idle(TICK_DIV * 4);

        // Reset in the first scan slot with button 0 still held.
        wait_tick();
        idle(1);
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        idle(TICK_DIV * 8);
        btn_raw = '0;
        idle(TICK_DIV * 5);

        // Randomized runs of button patterns, enable drops and resets.
        for (int r = 0; r < 70; r++) begin
            btn_raw = N_BTN'($urandom);
            enable  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) begin
                resetn = 1'b0;
                idle(1);
                resetn = 1'b1;
            end
            idle($urandom_range(1, 70));
        end

        enable  = 1'b1;
        btn_raw = '0;
        idle(TICK_DIV * 12);
        stim_done = 1'b1;
    end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Shared debounce and event scheduler for all crane-game control buttons (joystick directions and drop/claw).
- One tick divider and one time-multiplexed update path serve N_BTN buttons in turn.
- Produces a clean level per button, plus one-clock press, release and auto-repeat pulses for the game FSM.
- Replaces per-button slow-clock flip-flop chains; all logic runs on the system clock, with no derived clocks.

Parameters:
- N_BTN, 5: number of buttons scanned.
- TICK_DIV, 250000: system clocks per sample tick (2.5 ms at 100 MHz). Constraint: TICK_DIV >= N_BTN+2.
- STABLE_CNT, 4: consecutive differing samples required to accept a level change. Range 1..15.
- REPEAT_DELAY, 200: ticks of continuous hold before the first repeat pulse.
- REPEAT_RATE, 40: ticks between subsequent repeat pulses. Constraint: 1 <= REPEAT_RATE <= REPEAT_DELAY.

Ports:
- clock  in  1  system clock, 100 MHz
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  run sample ticks; when low, the tick counter is held at 0
- btn_raw  in  N_BTN  asynchronous raw button inputs, active-high
- btn_level  out  N_BTN  debounced level
- press_pulse  out  N_BTN  one-clock pulse on an accepted 0->1 transition
- release_pulse  out  N_BTN  one-clock pulse on an accepted 1->0 transition
- repeat_pulse  out  N_BTN  one-clock pulse during a sustained hold
- sample_tick  out  1  one-clock strobe at the start of each scan

Behaviour:
- Reset (asynchronous, resetn=0): all outputs 0. Synchronizers, stable counters, hold counters, tick counter and scan index all 0. FSM in IDLE.
- Input synchronizer: a two-flop chain per bit gives sync[i]. Latency is 2 clocks.
- Tick counter:
  - Runs 0..TICK_DIV-1 while enable=1; sample_tick=1 in the cycle the counter equals TICK_DIV-1.
  - enable=0 holds the counter at 0. A scan already in progress still completes.
- FSM states:
  - IDLE: on sample_tick go to SCAN with idx=0.
  - SCAN: process button idx for one clock; increment idx; after idx=N_BTN-1 return to IDLE.
  - A full scan takes N_BTN clocks.
- Per-button update when idx=i:
  - sync[i]==btn_level[i]: clear stable_cnt[i].
  - Otherwise increment stable_cnt[i]. When the incremented value reaches STABLE_CNT: toggle btn_level[i], clear stable_cnt[i], and assert press_pulse[i] (new level 1) or release_pulse[i] (new level 0).
  - Pulses are registered and appear in the clock after button i's scan slot. Each lasts exactly one clock.
- Hold and repeat, at button i's scan slot:
  - If btn_level[i]=1 and no toggle occurs this slot: increment hold_cnt[i].
  - When the incremented value equals REPEAT_DELAY: assert repeat_pulse[i] and load hold_cnt[i] with REPEAT_DELAY-REPEAT_RATE.
  - hold_cnt[i] is cleared on any toggle and whenever the level is 0.
  - Width is clog2(REPEAT_DELAY+1); the counter never wraps.
- Latency: a stable raw edge produces a pulse within 2 + STABLE_CNT*TICK_DIV + N_BTN + 1 clocks.
- Boundaries:
  - A bounce shorter than STABLE_CNT ticks never changes the level.
  - A press and a repeat never occur in the same slot; the toggle takes priority.
  - Several buttons may pulse in the same scan, but in different clocks.
  - Asserting resetn mid-scan aborts the scan immediately. A held button then produces a fresh press after STABLE_CNT ticks.

Decomposition:
- Shared package holds: the clog2 function, the default tick constants (TICK_DIV_2P5MS=250000), and the button index constants (BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_DROP).
- One sub-module, tick_gen: holds the divider counter and the enable input, and outputs sample_tick.
- Scan FSM and per-button state arrays stay in the top module.

Test Plan (N_BTN=2, TICK_DIV=8, STABLE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2, enable=1):
- Reset: hold resetn=0, toggle btn_raw -> all outputs 0. After release, first sample_tick arrives at clock 8, then every 8 clocks.
- Clean press: btn_raw[0]=1 held -> btn_level[0]=1 after the 3rd differing sample. press_pulse[0] high exactly 1 clock; no pulse on bit 1.
- Bounce rejection: btn_raw[1] toggles every 8 clocks, aligned to ticks, for 20 ticks -> btn_level[1] stays 0, no press or release pulses.
- Auto-repeat: hold btn_raw[0]=1 after press -> repeat_pulse[0] at the 5th tick after the press, then every 2 ticks. No repeat after release.
- Release: drop btn_raw[0] -> release_pulse[0] one clock after 3 ticks; hold_cnt cleared; btn_level[0]=0.
- Enable/reset mid-op: enable=0 for 40 clocks -> no sample_tick, levels retained. Pulse resetn low during SCAN -> outputs 0 at once; held button re-presses after 3 ticks.
